// File: rtl/mem_req_responder.sv
// Memory-side responder: one request in flight, response valid LAT cycles after accept.
// Backpressure: req_ready stays low until the owning requestor takes the held response.
module mem_req_responder #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic [ID_W-1:0]   io_req_bits_id,
    input  logic              io_req_bits_rw,
    input  logic [ADDR_W-1:0] io_req_bits_addr,
    input  logic [DATA_W-1:0] io_req_bits_wdata,
    output logic [N_REQ-1:0]  io_resp_valid,
    input  logic [N_REQ-1:0]  io_resp_ready,
    output logic              io_resp_bits_rw,
    output logic [DATA_W-1:0] io_resp_bits_data
);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [N_REQ-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic req_fire;
    logic resp_fire;
    logic id_in_range;
    logic mem_we;

    assign io_req_ready = (state_q == IDLE) & ~reset;
    assign req_fire     = io_req_valid & io_req_ready;
    // valid_q is one-hot on the owning channel, so this ignores ready on other channels
    assign resp_fire    = |(valid_q & io_resp_ready);
    assign id_in_range  = ({1'b0, id_q} < (ID_W + 1)'(N_REQ));

    assign io_resp_valid     = valid_q;
    assign io_resp_bits_rw   = rw_q;
    assign io_resp_bits_data = data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            rw_q    <= 1'b0;
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            rw_q    <= rw_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // The array is deliberately left out of reset so committed writes survive it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[io_req_bits_addr] <= io_req_bits_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = id_in_range ? RESP : IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        id_d    = id_q;
        rw_d    = rw_q;
        data_d  = data_q;
        valid_d = valid_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    id_d   = io_req_bits_id;
                    rw_d   = io_req_bits_rw;
                    mem_we = io_req_bits_rw;
                    data_d = io_req_bits_rw ? '0 : mem_q[io_req_bits_addr];
                end
            end
            BUSY: begin
                // An out-of-range id decodes to all-zero, so no channel sees a response
                if (cnt_q == '0) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        valid_d[i] = (id_q == ID_W'(i));
                    end
                end
            end
            RESP: begin
                if (resp_fire) begin
                    valid_d = '0;
                end
            end
            default: valid_d = '0;
        endcase
    end

    a_resp_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(valid_q));
    a_no_accept_while_resp: assert property (@(posedge clk) disable iff (reset)
        !(io_req_ready && (|valid_q)));

endmodule
